// File: rtl/fetch_unit_if.sv
// fetch_unit_if: controller/program-memory bus seen by the fetch unit
interface fetch_unit_if;
    logic        LoadIR;
    logic        IncPC;
    logic        LoadPC;
    logic        SelPC;
    logic [7:0]  RegVal;
    logic [11:0] MemData;
    logic        MemValid;
    logic        MemRd;
    logic [7:0]  MemAddr;
    logic [3:0]  Opcode;
    logic [7:0]  Imm;
    logic [3:0]  RegAddr;
    logic [7:0]  PC;
    logic        IRValid;
    logic        Halted;
    modport master (
        output LoadIR, IncPC, LoadPC, SelPC, RegVal, MemData, MemValid,
        input  MemRd, MemAddr, Opcode, Imm, RegAddr, PC, IRValid, Halted
    );
    modport slave (
        input  LoadIR, IncPC, LoadPC, SelPC, RegVal, MemData, MemValid,
        output MemRd, MemAddr, Opcode, Imm, RegAddr, PC, IRValid, Halted
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: FETCH/WAIT/EXEC/HALT instruction fetcher with PC and IR
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input logic          clk,
    input logic          CLB,
    fetch_unit_if.slave  bus
);
    typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_e;
    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [11:0] ir_q, ir_d;
    always_ff @(posedge clk) begin
        if (CLB) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 12'h000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
    // Untaken branches and plain increments both advance by one, so IncPC only matters as a request
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: state_d = WAIT;
            WAIT: if (bus.MemValid) begin
                ir_d    = bus.MemData;
                state_d = EXEC;
            end
            EXEC: if (ir_q[11:8] == 4'hF) begin
                state_d = HALT;
            end else if (bus.LoadIR) begin
                state_d = FETCH;
                pc_d    = bus.LoadPC ? (bus.SelPC ? bus.RegVal : ir_q[7:0]) : pc_q + 8'd1;
            end
            default: state_d = HALT;
        endcase
    end
    assign bus.MemRd   = !CLB && state_q == FETCH;
    assign bus.IRValid = !CLB && state_q == EXEC;
    assign bus.Halted  = !CLB && state_q == HALT;
    assign bus.Opcode  = CLB ? 4'h0 : ir_q[11:8];
    assign bus.Imm     = CLB ? 8'h00 : ir_q[7:0];
    assign bus.RegAddr = CLB ? 4'h0 : ir_q[3:0];
    assign bus.PC      = CLB ? RESET_PC : pc_q;
    assign bus.MemAddr = CLB ? RESET_PC : pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, jumps, stalls, wrap, halt and reset
module tb_fetch_unit;
    logic clk = 1'b0;
    logic CLB;
    int   total = 0;
    int   bad   = 0;
    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(8'h00)) dut (.clk(clk), .CLB(CLB), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.LoadIR = 0; bus.IncPC = 0; bus.LoadPC = 0; bus.SelPC = 0;
        bus.RegVal = 8'h00; bus.MemValid = 0; bus.MemData = 12'h000;
    endtask

    // Enter with the DUT in FETCH at address pc; leave it in EXEC holding data
    task automatic fetch_instr(input logic [7:0] pc, input logic [11:0] data, input int delay);
        chk("fetch_rd", 16'(bus.MemRd), 16'd1);
        chk("fetch_addr", 16'(bus.MemAddr), 16'(pc));
        step();
        for (int i = 0; i < delay; i++) begin
            chk("wait_rd", 16'(bus.MemRd), 16'd0);
            chk("wait_irv", 16'(bus.IRValid), 16'd0);
            step();
        end
        chk("wait_rd_last", 16'(bus.MemRd), 16'd0);
        bus.MemValid = 1; bus.MemData = data;
        step();
        bus.MemValid = 0; bus.MemData = 12'h000;
        chk("exec_irv", 16'(bus.IRValid), 16'd1);
        chk("exec_op", 16'(bus.Opcode), 16'(data[11:8]));
        chk("exec_imm", 16'(bus.Imm), 16'(data[7:0]));
        chk("exec_ra", 16'(bus.RegAddr), 16'(data[3:0]));
    endtask

    // Retire the instruction in EXEC and check the next fetch address
    task automatic retire(input logic ldpc, input logic inc, input logic sel, input logic [7:0] rv,
                          input logic [7:0] next_pc, input string tag);
        bus.LoadIR = 1; bus.LoadPC = ldpc; bus.IncPC = inc; bus.SelPC = sel; bus.RegVal = rv;
        step();
        clear_ctl();
        chk({tag, "_rd"}, 16'(bus.MemRd), 16'd1);
        chk({tag, "_addr"}, 16'(bus.MemAddr), 16'(next_pc));
        chk({tag, "_pc"}, 16'(bus.PC), 16'(next_pc));
    endtask

    initial begin
        clear_ctl();
        CLB = 1;
        step();
        step();
        chk("rst_rd", 16'(bus.MemRd), 16'd0);
        chk("rst_irv", 16'(bus.IRValid), 16'd0);
        chk("rst_halt", 16'(bus.Halted), 16'd0);
        chk("rst_op", 16'(bus.Opcode), 16'd0);
        chk("rst_imm", 16'(bus.Imm), 16'd0);
        chk("rst_ra", 16'(bus.RegAddr), 16'd0);
        chk("rst_pc", 16'(bus.PC), 16'd0);
        CLB = 0;
        #1;
        // straight line, 3-cycle period
        fetch_instr(8'h00, 12'h1AB, 0);
        retire(0, 1, 0, 8'h00, 8'h01, "line");
        // jumps: immediate, register, and LoadPC over IncPC
        fetch_instr(8'h01, 12'h742, 0);
        retire(1, 0, 0, 8'h00, 8'h42, "jimm");
        fetch_instr(8'h42, 12'h742, 0);
        retire(1, 0, 1, 8'h9C, 8'h9C, "jreg");
        fetch_instr(8'h9C, 12'h755, 0);
        retire(1, 1, 0, 8'h00, 8'h55, "jpri");
        // wait states and stall; MemValid during EXEC must be ignored
        fetch_instr(8'h55, 12'h3C7, 4);
        for (int i = 0; i < 3; i++) begin
            bus.LoadPC = 1; bus.IncPC = 1; bus.MemValid = 1; bus.MemData = 12'hEEE;
            step();
            chk("stall_irv", 16'(bus.IRValid), 16'd1);
            chk("stall_pc", 16'(bus.PC), 16'h55);
            chk("stall_op", 16'(bus.Opcode), 16'h3);
            chk("stall_imm", 16'(bus.Imm), 16'hC7);
            chk("stall_rd", 16'(bus.MemRd), 16'd0);
        end
        clear_ctl();
        retire(0, 0, 0, 8'h00, 8'h56, "unstall");
        // wrap and untaken
        fetch_instr(8'h56, 12'h7FF, 0);
        retire(1, 0, 0, 8'h00, 8'hFF, "toff");
        fetch_instr(8'hFF, 12'h123, 0);
        retire(0, 1, 0, 8'h00, 8'h00, "wrap");
        fetch_instr(8'h00, 12'h610, 0);
        retire(0, 0, 0, 8'h00, 8'h01, "untaken");
        // halt ignores the controller and memory
        fetch_instr(8'h01, 12'hF00, 0);
        bus.LoadIR = 1; bus.IncPC = 1; bus.LoadPC = 1; bus.SelPC = 1; bus.RegVal = 8'h77;
        step();
        chk("halt_set", 16'(bus.Halted), 16'd1);
        for (int i = 0; i < 20; i++) begin
            bus.MemValid = i[0]; bus.LoadIR = ~i[0]; bus.MemData = 12'hABC;
            step();
            chk("halt_rd", 16'(bus.MemRd), 16'd0);
            chk("halt_hld", 16'(bus.Halted), 16'd1);
            chk("halt_irv", 16'(bus.IRValid), 16'd0);
            chk("halt_pc", 16'(bus.PC), 16'h01);
            chk("halt_op", 16'(bus.Opcode), 16'hF);
        end
        clear_ctl();
        CLB = 1;
        step();
        chk("hrst_pc", 16'(bus.PC), 16'h00);
        chk("hrst_halt", 16'(bus.Halted), 16'd0);
        chk("hrst_rd", 16'(bus.MemRd), 16'd0);
        CLB = 0;
        #1;
        chk("hrel_rd", 16'(bus.MemRd), 16'd1);
        chk("hrel_addr", 16'(bus.MemAddr), 16'h00);
        chk("hrel_op", 16'(bus.Opcode), 16'h0);
        // reset mid-WAIT discards a late response
        step();
        chk("mw_wait_rd", 16'(bus.MemRd), 16'd0);
        CLB = 1;
        step();
        CLB = 0; bus.MemValid = 1; bus.MemData = 12'hD55;
        #1;
        chk("mw_rd", 16'(bus.MemRd), 16'd1);
        chk("mw_addr", 16'(bus.MemAddr), 16'h00);
        step();
        bus.MemValid = 0; bus.MemData = 12'h000;
        chk("mw_op", 16'(bus.Opcode), 16'h0);
        chk("mw_imm", 16'(bus.Imm), 16'h00);
        chk("mw_irv", 16'(bus.IRValid), 16'd0);
        chk("mw_rd2", 16'(bus.MemRd), 16'd0);
        bus.MemValid = 1; bus.MemData = 12'h2A5;
        step();
        bus.MemValid = 0;
        chk("mw_recap_irv", 16'(bus.IRValid), 16'd1);
        chk("mw_recap_imm", 16'(bus.Imm), 16'hA5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
